// File: rtl/aes_block_serializer.sv
// -----------------------------------------------------------------------------
// aes_block_serializer
//
// Purpose:
//   Turns whole AES state or ciphertext blocks from the final round register
//   into a beat stream for the byte-wide output port. The input and output
//   sides both use valid/ready handshakes. A new block can be captured on the
//   same edge that the final beat of the current block transfers, so
//   back-to-back blocks stream with no idle cycle between them.
//
// Parameters:
//   DATA_W     block width in bits. It must be an integer multiple of OUT_W.
//   OUT_W      output beat width in bits.
//   MSB_FIRST  1: beat 0 is the top OUT_W bits (FIPS-197 byte order).
//              0: beat 0 is the bottom OUT_W bits.
//   CNT_W      width of the completed-block counter.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   in_data holds a block to be sent
//   in_ready   block is accepted this cycle (combinational, no path from in_valid)
//   in_data    block to serialize
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts the beat this cycle
//   out_data   current beat
//   out_last   current beat is the final beat of its block
//   blk_count  number of fully sent blocks, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module aes_block_serializer #(
    parameter int DATA_W    = 128,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  blk_count
);

    localparam int NBEATS = DATA_W / OUT_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_reg,     state_next;
    logic [DATA_W-1:0]   shift_reg,     shift_next;
    logic [BEAT_W-1:0]   beat_reg,      beat_next;
    logic [CNT_W-1:0]    blk_count_reg, blk_count_next;

    logic [DATA_W-1:0]   shifted;
    logic                last_beat;
    logic                beat_xfer;

    // The current beat always sits at the output end of the shift register.
    // Each transfer moves the next beat into that position and fills the
    // vacated end with zeros.
    generate
        if (NBEATS == 1) begin : g_single_beat
            assign shifted  = '0;
            assign out_data = shift_reg[OUT_W-1:0];
        end else if (MSB_FIRST) begin : g_msb_first
            assign shifted  = {shift_reg[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
            assign out_data = shift_reg[DATA_W-1 -: OUT_W];
        end else begin : g_lsb_first
            assign shifted  = {{OUT_W{1'b0}}, shift_reg[DATA_W-1:OUT_W]};
            assign out_data = shift_reg[OUT_W-1:0];
        end
    endgenerate

    assign last_beat = (beat_reg == BEAT_W'(NBEATS - 1));
    assign out_valid = (state_reg == SEND);
    assign out_last  = out_valid && last_beat;
    assign beat_xfer = out_valid && out_ready;
    // Accept the next block in IDLE, and also on the final-beat transfer.
    // The second case gives back-to-back streaming with no bubble.
    assign in_ready  = (state_reg == IDLE) || (beat_xfer && last_beat);
    assign blk_count = blk_count_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            beat_reg      <= '0;
            blk_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            beat_reg      <= beat_next;
            blk_count_reg <= blk_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        beat_next      = beat_reg;
        blk_count_next = blk_count_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    shift_next = in_data;
                    beat_next  = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                // When out_ready is low (a stall), nothing changes. The
                // current beat and out_last stay stable.
                if (beat_xfer) begin
                    if (last_beat) begin
                        blk_count_next = blk_count_reg + CNT_W'(1);
                        beat_next      = '0;
                        if (in_valid) begin
                            shift_next = in_data;
                        end else begin
                            // Going idle. out_data keeps the shifted-out
                            // residue, and downstream ignores it.
                            shift_next = shifted;
                            state_next = IDLE;
                        end
                    end else begin
                        shift_next = shifted;
                        beat_next  = beat_reg + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
